// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared fetch/decode definitions: default datapath width,
//                PC increment, reset PC and the {pc, inst} queue entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int              XLEN             = 32;
    localparam int              INC_BYTES        = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv_fetch_unit_if
//  Description : Fetch-stage bundle: redirect input, instruction-memory
//                request/response channel and the decode-side handshake.
//                master = fetch unit, slave = surrounding core / memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv_fetch_unit_if
    import rv_pkg::*;
#(
    parameter int WIDTH = XLEN
);

    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;

    logic             inst_valid;
    logic             inst_ready;
    logic [WIDTH-1:0] inst_data;
    logic [WIDTH-1:0] inst_pc;

    logic             misaligned;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst_data, inst_pc,
        output misaligned
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst_data, inst_pc,
        input  misaligned
    );

endinterface
`default_nettype wire

// File: rtl/rv_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rv_prefetch_fifo
//  Description : Synchronous DEPTH-entry FIFO with push, pop and flush.
//                Head data is read straight from the storage array so a
//                written entry is visible the cycle after the push.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_prefetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = $bits(fetch_entry_t)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int                 C_PTR_W = $clog2(DEPTH);
    localparam int                 C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == C_DEPTH);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            r_count <= r_count + C_CNT_W'(w_do_push) - C_CNT_W'(w_do_pop);
        end
    end

    // Entry storage; contents need no reset since the count guards them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rv_fetch_unit
//  Description : Instruction-fetch stage. Owns the fetch PC, issues pipelined
//                requests to instruction memory limited by queue credits,
//                buffers {pc, inst} pairs in a prefetch FIFO and hands them to
//                decode. A redirect flushes the FIFO and marks every
//                in-flight response as stale.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int               INC      = INC_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    rv_fetch_unit_if.master bus
);

    localparam int                 C_CNT_W      = $clog2(DEPTH) + 1;
    localparam int                 C_SUM_W      = C_CNT_W + 1;
    localparam int                 C_ENTRY_W    = 2 * WIDTH;
    localparam logic [WIDTH-1:0]   C_INC        = WIDTH'(INC);
    localparam logic [WIDTH-1:0]   C_ALIGN_MASK = WIDTH'(INC - 1);
    localparam logic [C_SUM_W-1:0] C_DEPTH_EXT  = C_SUM_W'(DEPTH);

    // r_rsp_pc is the address of the next response that will be kept; since
    // responses return in order and kept requests are sequential from the
    // last redirect target, a running counter replaces a per-request tag.
    logic [WIDTH-1:0]     r_fetch_pc;
    logic [WIDTH-1:0]     r_rsp_pc;
    logic [C_CNT_W-1:0]   r_outstanding;
    logic [C_CNT_W-1:0]   r_drop;
    logic                 r_misaligned;

    logic [C_CNT_W-1:0]   w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [C_ENTRY_W-1:0] w_fifo_rdata;
    logic [C_ENTRY_W-1:0] w_fifo_wdata;

    logic [C_SUM_W-1:0]   w_occupancy;
    logic [C_CNT_W-1:0]   w_outstanding_nxt;
    logic [WIDTH-1:0]     w_redirect_target;
    logic                 w_redirect_misaligned;
    logic                 w_credit_ok;
    logic                 w_req_valid;
    logic                 w_fire;
    logic                 w_rsp;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_redirect;

    // Credits are what is left after queued entries and requests still in
    // flight; the sum is one bit wider so it cannot wrap.
    assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_credit_ok = ~w_fifo_full & (w_occupancy < C_DEPTH_EXT);

    // Held low while reset is asserted; otherwise purely a function of state.
    assign w_req_valid = rst & w_credit_ok;
    assign w_fire      = w_req_valid & bus.imem_req_ready;
    assign w_rsp       = bus.imem_rsp_valid;
    assign w_redirect  = bus.redirect_valid;
    assign w_pop       = ~w_fifo_empty & bus.inst_ready;

    // Stale responses (drop > 0) and any response in a redirect cycle vanish.
    assign w_push = w_rsp & (r_drop == '0) & ~w_redirect;

    assign w_outstanding_nxt = r_outstanding + C_CNT_W'(w_fire) - C_CNT_W'(w_rsp);

    assign w_redirect_target     = bus.redirect_pc & ~C_ALIGN_MASK;
    assign w_redirect_misaligned = (bus.redirect_pc & C_ALIGN_MASK) != '0;

    assign w_fifo_wdata = {r_rsp_pc, bus.imem_rsp_data};

    rv_prefetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (C_ENTRY_W)
    ) u_prefetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_redirect),
        .wdata (w_fifo_wdata),
        .rdata (w_fifo_rdata),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Fetch PC, response PC, in-flight/stale counters and misalignment flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_misaligned  <= w_redirect & w_redirect_misaligned;
            if (w_redirect) begin
                // Everything still in flight after this edge, including a
                // request fired right now, belongs to the old path.
                r_fetch_pc <= w_redirect_target;
                r_rsp_pc   <= w_redirect_target;
                r_drop     <= w_outstanding_nxt;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + C_INC;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + C_INC;
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - C_CNT_W'(1);
                end
            end
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = ~w_fifo_empty;
    assign bus.inst_pc        = w_fifo_rdata[C_ENTRY_W-1:WIDTH];
    assign bus.inst_data      = w_fifo_rdata[WIDTH-1:0];
    assign bus.misaligned     = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_fetch_unit
//  Description : Self-checking bench for rv_fetch_unit. A latency-randomised
//                memory drives the DUT; a transaction-level model predicts
//                the delivered instruction stream and handshake outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          INC      = 4;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_fetch_unit_if #(.WIDTH(32)) bus  ();
    rv_fetch_unit_if #(.WIDTH(32)) bus2 ();

    rv_fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .INC(INC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rv_fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC), .INC(INC)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // ---------------------------------------------------------------- model
    typedef struct { int unsigned due; logic [31:0] data; } env_t;
    typedef struct { logic [31:0] addr; bit stale; }        req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; }  ent_t;

    env_t        env_q[$];   // memory side: responses waiting to be returned
    req_t        mp[$];      // model: requests in flight, in issue order
    ent_t        mq[$];      // model: instructions ready for decode
    logic [31:0] m_fetch_pc;
    bit          m_mis;

    int          n_chk = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;

    int          rdy_pct, irdy_pct, lat_lo, lat_hi, redir_pm;
    bit          force_redir;
    logic [31:0] force_tgt;
    int          dut_fires, dut_pops;
    bit          await_first;
    logic [31:0] first_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0] ^ 8'hC3, a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        env_q.delete();
        mp.delete();
        mq.delete();
        m_fetch_pc = 32'h0;
        m_mis      = 1'b0;
    endtask

    // Hold reset for a few edges, check the reset-state outputs, release.
    // Returns at a falling edge with rst=1 (first active cycle).
    task automatic do_reset();
        rst                 = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus2.imem_req_ready = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        bus2.inst_ready     = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        model_reset();
        @(negedge clk);
        chk("rst_req_valid",  32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid),     32'd0);
        chk("rst_misaligned", 32'(bus.misaligned),     32'd0);
        chk("rst_req_addr",   bus.imem_req_addr,       32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One or more cycles of stimulus with full output prediction.
    task automatic run(input int n);
        bit          rsp, redir, exp_req, exp_iv, pop, fire;
        logic [31:0] tgt;
        req_t        r;
        ent_t        e;
        env_t        v;
        for (int c = 0; c < n; c++) begin
            bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
            bus.inst_ready     = ($urandom_range(99) < irdy_pct);
            redir              = force_redir || ($urandom_range(999) < redir_pm);
            tgt                = force_redir ? force_tgt : $urandom;
            bus.redirect_valid = redir;
            bus.redirect_pc    = redir ? tgt : $urandom;
            rsp                = (env_q.size() > 0) && (env_q[0].due <= cyc);
            bus.imem_rsp_valid = rsp;
            bus.imem_rsp_data  = rsp ? env_q[0].data : $urandom;
            #1;
            exp_req = (mq.size() + mp.size()) < DEPTH;
            exp_iv  = mq.size() > 0;
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            if (exp_req) chk("req_addr", bus.imem_req_addr, m_fetch_pc);
            chk("inst_valid", 32'(bus.inst_valid), 32'(exp_iv));
            if (exp_iv) begin
                chk("inst_pc",   bus.inst_pc,   mq[0].pc);
                chk("inst_data", bus.inst_data, mq[0].data);
            end
            chk("misaligned", 32'(bus.misaligned), 32'(m_mis));

            // memory environment reacts to what the DUT actually did
            if (rsp) void'(env_q.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                v.due  = cyc + $urandom_range(lat_hi, lat_lo);
                v.data = mem_word(bus.imem_req_addr);
                env_q.push_back(v);
                dut_fires++;
            end
            if (bus.inst_valid && bus.inst_ready) begin
                dut_pops++;
                if (await_first) begin
                    first_pc    = bus.inst_pc;
                    await_first = 1'b0;
                end
            end

            // model advance
            pop  = exp_iv && bus.inst_ready;
            fire = exp_req && bus.imem_req_ready;
            if (pop) void'(mq.pop_front());
            if (rsp && mp.size() > 0) begin
                r = mp.pop_front();
                if (!r.stale && !redir) begin
                    e.pc   = r.addr;
                    e.data = mem_word(r.addr);
                    mq.push_back(e);
                end
            end
            if (fire) begin
                r.addr  = m_fetch_pc;
                r.stale = 1'b0;
                mp.push_back(r);
                m_fetch_pc = m_fetch_pc + INC;
            end
            if (redir) begin
                mq.delete();
                for (int i = 0; i < mp.size(); i++) mp[i].stale = 1'b1;
                m_fetch_pc  = tgt & ~32'(INC - 1);
                m_mis       = (tgt & 32'(INC - 1)) != 0;
                await_first = 1'b1;
            end else begin
                m_mis = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic knobs(input int rdy, input int irdy, input int llo, input int lhi, input int rpm);
        rdy_pct  = rdy;
        irdy_pct = irdy;
        lat_lo   = llo;
        lat_hi   = lhi;
        redir_pm = rpm;
    endtask

    task automatic directed_redirect(input logic [31:0] tgt);
        force_redir = 1'b1;
        force_tgt   = tgt;
        first_pc    = 32'hDEAD_BEEF;
        run(1);
        force_redir = 1'b0;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        logic        last_fire;
        logic [31:0] last_addr;
        logic [31:0] exp2;
        int          pops2;

        force_redir = 1'b0;
        force_tgt   = '0;
        await_first = 1'b0;
        first_pc    = '0;
        knobs(100, 100, 1, 1, 0);
        do_reset();

        // wrap-around instance: memory always ready, 1-cycle latency
        last_fire = 1'b0;
        last_addr = '0;
        exp2      = WRAP_PC;
        pops2     = 0;
        for (int c = 0; c < 8; c++) begin
            bus2.imem_rsp_valid = last_fire;
            bus2.imem_rsp_data  = mem_word(last_addr);
            #1;
            if (bus2.inst_valid) begin
                chk("wrap_pc",   bus2.inst_pc,   exp2);
                chk("wrap_data", bus2.inst_data, mem_word(exp2));
                exp2 = exp2 + INC;
                pops2++;
            end
            last_fire = bus2.imem_req_valid;
            last_addr = bus2.imem_req_addr;
            @(negedge clk);
        end
        chk("wrap_pops", 32'(pops2), 32'd6);

        // streaming: one instruction per cycle after two cycles of latency
        do_reset();
        dut_pops = 0;
        knobs(100, 100, 1, 1, 0);
        run(30);
        chk("thruput", 32'(dut_pops), 32'd28);

        // decode stalled: only DEPTH requests may be issued
        do_reset();
        dut_fires = 0;
        knobs(100, 0, 1, 1, 0);
        run(10);
        chk("stall_fires", 32'(dut_fires), 32'(DEPTH));
        knobs(100, 100, 1, 1, 0);
        run(12);

        // three slow requests in flight, then redirect
        do_reset();
        knobs(100, 100, 5, 5, 0);
        run(3);
        knobs(0, 100, 5, 5, 0);
        directed_redirect(32'h0000_0100);
        knobs(100, 100, 5, 5, 0);
        run(20);
        chk("redir_slow_first_pc", first_pc, 32'h0000_0100);

        // redirect coinciding with a request fire and a response
        do_reset();
        knobs(100, 100, 1, 1, 0);
        run(6);
        directed_redirect(32'h0000_0200);
        run(10);
        chk("redir_busy_first_pc", first_pc, 32'h0000_0200);

        // misaligned target
        directed_redirect(32'h0000_0102);
        chk("misaligned_set", 32'(bus.misaligned), 32'd1);
        run(1);
        chk("misaligned_clr", 32'(bus.misaligned), 32'd0);
        run(10);
        chk("misaligned_first_pc", first_pc, 32'h0000_0100);

        // random traffic, then reset in the middle of it
        knobs(70, 70, 1, 4, 30);
        run(1500);
        knobs(90, 90, 3, 3, 0);
        run(25);
        do_reset();
        knobs(60, 50, 2, 6, 40);
        run(1500);
        knobs(100, 100, 1, 1, 0);
        run(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_fetch_unit.md
# rv_fetch_unit

Parametrised instruction-fetch stage that replaces the free-running PC register and combinational instruction-memory read in the single-cycle core. It owns the fetch PC, issues pipelined requests to instruction memory over a valid/ready interface, buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, and presents them to decode over a valid/ready handshake. A branch/jump redirect flushes the queue and discards in-flight responses.

## Interface
- WIDTH, 32: address and instruction width in bits.
- DEPTH, 4: prefetch queue entries; power of two, ≥ 2; also the cap on queued plus outstanding requests.
- RESET_PC, 32'h0: fetch PC after reset.
- INC, 4: PC increment per instruction, in bytes.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset: rst=0 at a rising edge resets.
- redirect_valid  in  1  branch/jump taken; has priority over all other events.
- redirect_pc  in  WIDTH  absolute target address.
- imem_req_valid  out  1  request pending.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  WIDTH  request address.
- imem_rsp_valid  in  1  response data valid; responses return in order, one per accepted request, latency ≥ 1 cycle.
- imem_rsp_data  in  WIDTH  instruction word.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  WIDTH  head instruction.
- inst_pc  out  WIDTH  head PC.
- misaligned  out  1  registered; set for one cycle when a redirect_pc is not INC-aligned.

## Operation
- State: fetch_pc, queue (rd/wr pointers, count), outstanding counter, drop counter. Counters are $clog2(DEPTH)+1 bits wide.
- Credits = DEPTH − count − outstanding. imem_req_valid = (credits > 0), with imem_req_addr = fetch_pc.
- imem_req_valid depends only on state, never combinationally on imem_req_ready.
- Request fire (valid & ready): fetch_pc += INC (modulo 2^WIDTH, wraps silently) and outstanding += 1.
- Response (imem_rsp_valid):
  - outstanding −= 1.
  - If drop > 0: drop −= 1 and the data is discarded.
  - Otherwise {fetch address, data} is written to the queue. The credit rule guarantees a free slot.
- Pop on inst_valid & inst_ready.
- Redirect cycle, all in the same edge:
  - Queue cleared.
  - fetch_pc ← redirect_pc with low $clog2(INC) bits forced to 0.
  - drop ← next-cycle outstanding value; this includes a request fired and any response arriving in the same cycle, both counted as stale.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle completes normally.
- Simultaneous fire, response and pop without redirect: all applied; count and outstanding net correctly.

## Timing
- Reset values: imem_req_valid=0 during reset, inst_valid=0, misaligned=0, fetch_pc=RESET_PC, count=outstanding=drop=0.
- First request is issued in the first cycle after rst returns to 1.
- Response in cycle r → inst_valid in cycle r+1. No bypass.
- Redirect in cycle t:
  - inst_valid=0 in cycle t+1.
  - A request to the new PC is issued in t+1 if credits > 0.
- Full queue (count=DEPTH): imem_req_valid=0 until a pop occurs.
- Throughput: one instruction per cycle with single-cycle memory and inst_ready held high.

## Structure
- Shared package rv_pkg holds the WIDTH default, INC, RESET_PC default and the {pc, inst} entry struct, shared with decode.
- One sub-module, rv_prefetch_fifo: a synchronous FIFO of DEPTH entries with push, pop and flush, and count/full/empty outputs.
- The top module keeps fetch_pc, the outstanding/drop counters and the handshake logic.

## Test plan
- Reset, then memory always ready with 1-cycle latency and inst_ready=1 → inst_pc sequence 0x0, 0x4, 0x8… at one per cycle; inst_data matches the memory model.
- inst_ready=0 for 10 cycles with DEPTH=4 → exactly 4 requests issued, imem_req_valid=0 afterwards, queue holds PCs 0x0–0xC and none are lost on release.
- 3 outstanding requests at 5-cycle latency, redirect to 0x100 → the 3 stale responses are dropped; next inst_pc=0x100.
- Redirect in the same cycle as a request fire and a response → both treated as stale; first delivered inst_pc = redirect target.
- redirect_pc=0x102 → misaligned=1 for one cycle; fetch resumes at 0x100.
- RESET_PC=0xFFFFFFFC → PCs 0xFFFFFFFC then 0x00000000 (wrap). Reset asserted mid-stream with outstanding requests → all outputs at reset values the next cycle.
